// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - re-encodes a decoded control bundle into 32-bit ARM-style words and writes them to instruction memory
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake for one control bundle
//   alu_cmd .. br_offset  decoded control bundle fields
//   flush                 restart program (pointer and count back to 0)
//   imem_we/addr/wdata    instruction-memory write, held until imem_ack
//   imem_ack              memory accepted the write
//   instr_count           words written since reset/flush
//   full                  instr_count == DEPTH
//   illegal               one-cycle pulse after an unencodable request is consumed
module instr_encoder #(
  parameter int          ADDR_W    = 10,
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        alu_cmd,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              wb_en,
  input  logic              branch,
  input  logic              s_bit,
  input  logic [3:0]        cond,
  input  logic              imm,
  input  logic [3:0]        rn,
  input  logic [3:0]        rd,
  input  logic [11:0]       shift_op,
  input  logic [23:0]       br_offset,
  input  logic              flush,
  output logic              imem_we,
  output logic [31:0]       imem_addr,
  output logic [31:0]       imem_wdata,
  input  logic              imem_ack,
  output logic [ADDR_W:0]   instr_count,
  output logic              full,
  output logic              illegal
);

  typedef enum logic {IDLE, WRITE} state_t;

  localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];

  state_t            state, state_nxt;
  logic [ADDR_W:0]   count, count_nxt;
  logic              flush_pending, pending_nxt;
  logic [31:0]       word, word_nxt;
  logic              illegal_nxt;

  logic [3:0]        opc;
  logic              opc_ok;
  logic [31:0]       enc_word;
  logic              enc_ok;

  // The write pointer always equals the number of words written, so the
  // count doubles as the pointer. When full the pointer may alias, but no
  // write can start then.
  logic [ADDR_W-1:0] ptr;
  assign ptr = count[ADDR_W-1:0];

  assign imem_addr   = BASE_ADDR + 32'({ptr, 2'b00});
  assign imem_we     = (state == WRITE);
  assign imem_wdata  = word;
  assign instr_count = count;
  assign full        = (count == DEPTH_C);

  // ALU command to data-processing opcode
  always_comb begin
    opc    = 4'b0000;
    opc_ok = 1'b0;
    if (wb_en) begin
      opc_ok = 1'b1;
      case (alu_cmd)
        4'b0001: opc = 4'b1101;
        4'b1001: opc = 4'b1111;
        4'b0010: opc = 4'b0100;
        4'b0011: opc = 4'b0101;
        4'b0100: opc = 4'b0010;
        4'b0101: opc = 4'b0110;
        4'b0110: opc = 4'b0000;
        4'b0111: opc = 4'b1100;
        4'b1000: opc = 4'b0001;
        default: opc_ok = 1'b0;
      endcase
    end else begin
      // compare-only forms exist solely to set flags
      case (alu_cmd)
        4'b0100: begin opc = 4'b1010; opc_ok = s_bit; end
        4'b0110: begin opc = 4'b1000; opc_ok = s_bit; end
        default: opc_ok = 1'b0;
      endcase
    end
  end

  // Instruction word assembly and legality
  always_comb begin
    enc_word = 32'h0;
    enc_ok   = 1'b0;
    if (branch) begin
      enc_word = {cond, 3'b101, 1'b0, br_offset};
      enc_ok   = 1'b1;
    end else if (mem_read || mem_write) begin
      enc_word = {cond, 2'b01, 1'b0, 4'b0100, mem_read, rn, rd, shift_op};
      enc_ok   = !(mem_read && mem_write) && (alu_cmd == 4'b0010) &&
                 !(mem_read && !wb_en) && !(mem_write && wb_en);
    end else begin
      enc_word = {cond, 2'b00, imm, opc, s_bit, rn, rd, shift_op};
      enc_ok   = opc_ok;
    end
  end

  always_comb begin
    state_nxt   = state;
    count_nxt   = count;
    pending_nxt = flush_pending;
    word_nxt    = word;
    illegal_nxt = 1'b0;
    req_ready   = 1'b0;
    case (state)
      IDLE: begin
        req_ready = !full && !flush;
        if (flush) begin
          count_nxt = '0;
        end else if (req_valid && req_ready) begin
          if (enc_ok) begin
            word_nxt  = enc_word;
            state_nxt = WRITE;
          end else begin
            illegal_nxt = 1'b1;
          end
        end
      end
      WRITE: begin
        if (flush) pending_nxt = 1'b1;
        if (imem_ack) begin
          state_nxt   = IDLE;
          pending_nxt = 1'b0;
          // a flush seen at any point of this write restarts the program
          count_nxt   = (flush_pending || flush) ? '0 : count + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      count         <= '0;
      flush_pending <= 1'b0;
      word          <= 32'h0;
      illegal       <= 1'b0;
    end else begin
      state         <= state_nxt;
      count         <= count_nxt;
      flush_pending <= pending_nxt;
      word          <= word_nxt;
      illegal       <= illegal_nxt;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - self-checking bench for instr_encoder
module tb_instr_encoder;

  localparam int          AW   = 3;
  localparam int          DEP  = 4;
  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk, rst_n, req_valid, req_ready;
  logic [3:0]  alu_cmd, cond, rn, rd;
  logic        mem_read, mem_write, wb_en, branch, s_bit, imm, flush;
  logic [11:0] shift_op;
  logic [23:0] br_offset;
  logic        imem_we, imem_ack, full, illegal;
  logic [31:0] imem_addr, imem_wdata;
  logic [AW:0] instr_count;

  instr_encoder #(.ADDR_W(AW), .DEPTH(DEP), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .alu_cmd(alu_cmd), .mem_read(mem_read), .mem_write(mem_write), .wb_en(wb_en),
    .branch(branch), .s_bit(s_bit), .cond(cond), .imm(imm), .rn(rn), .rd(rd),
    .shift_op(shift_op), .br_offset(br_offset), .flush(flush),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .imem_ack(imem_ack), .instr_count(instr_count), .full(full), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
  endtask

  // Expected observable state, maintained at transaction level
  bit          mon_en = 0;
  bit          m_we = 0;
  bit          m_illegal = 0;
  logic [31:0] m_word = 0;
  logic [31:0] m_addr = 0;
  int          m_count = 0;

  // opcode table for write-back commands: {valid, opc}
  logic [4:0] wb_tab [16];

  function automatic logic [32:0] enc_model();
    logic [4:0] e;
    if (branch) return {1'b1, cond, 4'b1010, br_offset};
    if (mem_read || mem_write)
      return {(mem_read ^ mem_write) && (alu_cmd == 4'h2) && (wb_en == mem_read),
              cond, 7'b0100100, mem_read, rn, rd, shift_op};
    if (wb_en) e = wb_tab[alu_cmd];
    else if (s_bit && alu_cmd == 4'h4) e = 5'h1A;
    else if (s_bit && alu_cmd == 4'h6) e = 5'h18;
    else e = 5'h00;
    return {e[4], cond, 2'b00, imm, e[3:0], s_bit, rn, rd, shift_op};
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      chk("we", imem_we, m_we);
      if (m_we) begin
        chk("wdata", imem_wdata, m_word);
        chk("addr", imem_addr, m_addr);
      end
      chk("count", instr_count, m_count);
      chk("full", full, m_count == DEP);
      chk("illegal", illegal, m_illegal);
    end
  end

  // Issue one request (called at posedge+1). flush_at pulses flush in that wait cycle.
  task automatic do_req(input int ack_dly, input logic [31:0] lit, input logic [31:0] lit_addr,
                        input bit use_lit, input int flush_at);
    logic [32:0] e;
    bit pend;
    e = enc_model();
    req_valid = 1'b1;
    #1 chk("req_ready", req_ready, 1'b1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (e[32]) begin
      m_we = 1; m_word = e[31:0]; m_addr = BASE + 32'(4 * m_count);
      if (use_lit) begin
        chk("lit_word", imem_wdata, lit);
        chk("lit_addr", imem_addr, lit_addr);
      end
      pend = 0;
      for (int i = 0; i < ack_dly; i++) begin
        if (i == flush_at) begin flush = 1'b1; pend = 1; end
        @(posedge clk); #1;
        flush = 1'b0;
      end
      imem_ack = 1'b1;
      @(posedge clk); #1;
      imem_ack = 1'b0;
      m_we = 0;
      m_count = pend ? 0 : m_count + 1;
      chk("ready_after", req_ready, m_count != DEP);
    end else begin
      m_illegal = 1;
      @(posedge clk); #1;
      m_illegal = 0;
    end
  endtask

  task automatic fields(input logic [3:0] a, input logic w, input logic s, input logic i,
                        input logic [3:0] c, input logic [3:0] n, input logic [3:0] d,
                        input logic [11:0] op);
    alu_cmd = a; wb_en = w; s_bit = s; imm = i; cond = c; rn = n; rd = d; shift_op = op;
    mem_read = 0; mem_write = 0; branch = 0; br_offset = 24'h0;
  endtask

  initial begin
    for (int k = 0; k < 16; k++) wb_tab[k] = 5'h00;
    wb_tab[4'h1] = {1'b1, 4'b1101}; wb_tab[4'h9] = {1'b1, 4'b1111};
    wb_tab[4'h2] = {1'b1, 4'b0100}; wb_tab[4'h3] = {1'b1, 4'b0101};
    wb_tab[4'h4] = {1'b1, 4'b0010}; wb_tab[4'h5] = {1'b1, 4'b0110};
    wb_tab[4'h6] = {1'b1, 4'b0000}; wb_tab[4'h7] = {1'b1, 4'b1100};
    wb_tab[4'h8] = {1'b1, 4'b0001};

    rst_n = 0; req_valid = 0; flush = 0; imem_ack = 0;
    fields(4'h0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 12'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", imem_we, 1'b0);
    chk("rst_addr", imem_addr, BASE);
    chk("rst_wdata", imem_wdata, 32'h0);
    chk("rst_illegal", illegal, 1'b0);
    chk("rst_full", full, 1'b0);
    chk("rst_count", instr_count, 0);
    rst_n = 1; mon_en = 1;
    @(posedge clk); #1;
    chk("ready_idle", req_ready, 1'b1);

    // illegal requests
    fields(4'hF, 1, 0, 0, 4'hE, 4'h1, 4'h2, 12'h0);
    do_req(0, 0, 0, 0, -1);
    fields(4'h4, 0, 0, 0, 4'hE, 4'h3, 4'h0, 12'h004);
    do_req(0, 0, 0, 0, -1);
    fields(4'h2, 1, 0, 0, 4'hE, 4'h1, 4'h0, 12'h008);
    mem_read = 1; mem_write = 1;
    do_req(0, 0, 0, 0, -1);

    // ADD, CMP, LDR, B fill the DEPTH=4 program
    fields(4'h2, 1, 0, 1, 4'hE, 4'h2, 4'h1, 12'h005);
    do_req(0, 32'hE2821005, BASE, 1, -1);
    fields(4'h4, 0, 1, 0, 4'hE, 4'h3, 4'h0, 12'h004);
    do_req(3, 32'hE1530004, BASE + 4, 1, -1);
    fields(4'h2, 1, 0, 0, 4'hE, 4'h1, 4'h0, 12'h008);
    mem_read = 1;
    do_req(3, 32'hE4910008, BASE + 8, 1, -1);
    fields(4'h2, 1, 0, 0, 4'h0, 4'h0, 4'h0, 12'h0);
    branch = 1; br_offset = 24'hFFFFFE;
    do_req(1, 32'h0AFFFFFE, BASE + 12, 1, -1);

    // full: held request is not accepted
    req_valid = 1;
    for (int k = 0; k < 3; k++) begin
      #1 chk("full_ready", req_ready, 1'b0);
      @(posedge clk); #1;
    end
    // flush beats a valid request
    flush = 1;
    #1 chk("flush_ready", req_ready, 1'b0);
    @(posedge clk); #1;
    flush = 0; req_valid = 0; m_count = 0;

    fields(4'h2, 1, 0, 1, 4'hE, 4'h2, 4'h1, 12'h005);
    do_req(0, 32'hE2821005, BASE, 1, -1);
    // ORRS with flush during the wait
    fields(4'h7, 1, 1, 0, 4'hE, 4'h4, 4'h5, 12'h0F0);
    do_req(3, 32'hE19450F0, BASE + 4, 1, 1);
    // MVN after pending flush lands at BASE
    fields(4'h9, 1, 0, 1, 4'hE, 4'h0, 4'h7, 12'h0FF);
    do_req(0, 32'hE3E070FF, BASE, 1, -1);

    // reset in the middle of a write
    fields(4'h8, 1, 0, 0, 4'hE, 4'h1, 4'h2, 12'h003);
    req_valid = 1;
    @(posedge clk); #1;
    req_valid = 0;
    m_we = 1; m_word = enc_model() & 32'hFFFF_FFFF; m_addr = BASE + 32'(4 * m_count);
    @(posedge clk); #1;
    rst_n = 0; m_we = 0; m_count = 0;
    #1;
    chk("rst_mid_we", imem_we, 1'b0);
    chk("rst_mid_count", instr_count, 0);
    @(posedge clk); #1;
    rst_n = 1;
    fields(4'h2, 1, 0, 1, 4'hE, 4'h2, 4'h1, 12'h005);
    do_req(0, 32'hE2821005, BASE, 1, -1);

    mon_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
